// File: rtl/id_decode_reg.sv
// ID-stage decoder and pipeline register for the LA32R subset.
// It decodes the word offered by IF and holds the EX operand-select fields for one stage.

`ifndef OP_NOP
`define OP_NOP   8'd0
`define OP_ADD   8'd1
`define OP_SUB   8'd2
`define OP_SLT   8'd3
`define OP_SLTU  8'd4
`define OP_NOR   8'd5
`define OP_AND   8'd6
`define OP_OR    8'd7
`define OP_XOR   8'd8
`define OP_SLL   8'd9
`define OP_SRL   8'd10
`define OP_SRA   8'd11
`define OP_SLLI  8'd12
`define OP_SRLI  8'd13
`define OP_SRAI  8'd14
`define OP_SLTI  8'd15
`define OP_SLTUI 8'd16
`define OP_ADDI  8'd17
`define OP_ANDI  8'd18
`define OP_ORI   8'd19
`define OP_XORI  8'd20
`define OP_LD_W  8'd21
`define OP_ST_W  8'd22
`define OP_LL_W  8'd23
`define OP_SC_W  8'd24
`endif

`ifndef OP_TYPE_NONE
`define OP_TYPE_NONE  4'd0
`define OP_TYPE_3R    4'd1
`define OP_TYPE_2RI12 4'd2
`define OP_TYPE_2RI14 4'd3
`endif

`ifndef IMM_SZ_NONE
`define IMM_SZ_NONE 3'd0
`define IMM_SZ_12   3'd1
`define IMM_SZ_14   3'd2
`endif

module id_decode_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            fs_to_ds_valid,
    input  logic [31:0]     fs_inst,
    input  logic [PC_W-1:0] fs_pc,
    output logic            ds_allowin,
    input  logic            es_allowin,
    output logic            ds_to_es_valid,
    output logic [PC_W-1:0] ds_pc,
    output logic [7:0]      op,
    output logic [3:0]      op_type,
    output logic [4:0]      rd,
    output logic [4:0]      rj,
    output logic [4:0]      rk,
    output logic [25:0]     imm_unext,
    output logic [2:0]      imm_sz,
    output logic [4:0]      shift_imm,
    output logic            flag_unsigned,
    output logic            ine
);

    logic            ds_valid_reg;
    logic [PC_W-1:0] ds_pc_reg;
    logic [7:0]      op_reg, op_next;
    logic [3:0]      op_type_reg, op_type_next;
    logic [4:0]      rd_reg, rj_reg, rk_reg;
    logic [25:0]     imm_unext_reg, imm_unext_next;
    logic [2:0]      imm_sz_reg, imm_sz_next;
    logic [4:0]      shift_imm_reg, shift_imm_next;
    logic            flag_unsigned_reg, flag_unsigned_next;
    logic            ine_reg, ine_next;

    logic [7:0] op_3r, op_12, op_14;
    logic       hit_3r, hit_12, hit_14, shift_form;
    logic       load_fields;

    // Three independent key lookups; the LA32R encodings never overlap between formats.
    always_comb begin
        op_3r      = `OP_NOP;
        hit_3r     = 1'b1;
        shift_form = 1'b0;
        case (fs_inst[31:15])
            17'h00020: op_3r = `OP_ADD;
            17'h00022: op_3r = `OP_SUB;
            17'h00024: op_3r = `OP_SLT;
            17'h00025: op_3r = `OP_SLTU;
            17'h00028: op_3r = `OP_NOR;
            17'h00029: op_3r = `OP_AND;
            17'h0002a: op_3r = `OP_OR;
            17'h0002b: op_3r = `OP_XOR;
            17'h0002e: op_3r = `OP_SLL;
            17'h0002f: op_3r = `OP_SRL;
            17'h00030: op_3r = `OP_SRA;
            17'h00081: begin op_3r = `OP_SLLI; shift_form = 1'b1; end
            17'h00089: begin op_3r = `OP_SRLI; shift_form = 1'b1; end
            17'h00091: begin op_3r = `OP_SRAI; shift_form = 1'b1; end
            default:   hit_3r = 1'b0;
        endcase

        op_12  = `OP_NOP;
        hit_12 = 1'b1;
        case (fs_inst[31:22])
            10'h008: op_12 = `OP_SLTI;
            10'h009: op_12 = `OP_SLTUI;
            10'h00a: op_12 = `OP_ADDI;
            10'h00d: op_12 = `OP_ANDI;
            10'h00e: op_12 = `OP_ORI;
            10'h00f: op_12 = `OP_XORI;
            10'h0a2: op_12 = `OP_LD_W;
            10'h0a6: op_12 = `OP_ST_W;
            default: hit_12 = 1'b0;
        endcase

        op_14  = `OP_NOP;
        hit_14 = 1'b1;
        case (fs_inst[31:24])
            8'h20:   op_14 = `OP_LL_W;
            8'h21:   op_14 = `OP_SC_W;
            default: hit_14 = 1'b0;
        endcase
    end

    always_comb begin
        op_next            = `OP_NOP;
        op_type_next       = `OP_TYPE_NONE;
        imm_sz_next        = `IMM_SZ_NONE;
        imm_unext_next     = '0;
        shift_imm_next     = '0;
        flag_unsigned_next = 1'b0;
        ine_next           = 1'b0;
        if (hit_3r) begin
            op_next        = op_3r;
            op_type_next   = `OP_TYPE_3R;
            shift_imm_next = shift_form ? fs_inst[14:10] : 5'd0;
        end else if (hit_12) begin
            op_next            = op_12;
            op_type_next       = `OP_TYPE_2RI12;
            imm_sz_next        = `IMM_SZ_12;
            imm_unext_next     = {14'd0, fs_inst[21:10]};
            flag_unsigned_next = (op_12 == `OP_ANDI) || (op_12 == `OP_ORI) || (op_12 == `OP_XORI);
        end else if (hit_14) begin
            op_next        = op_14;
            op_type_next   = `OP_TYPE_2RI14;
            imm_sz_next    = `IMM_SZ_14;
            imm_unext_next = {12'd0, fs_inst[23:10]};
        end else begin
            ine_next = 1'b1;
        end
    end

    assign ds_allowin  = !ds_valid_reg || es_allowin;
    assign load_fields = ds_allowin && fs_to_ds_valid && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_reg      <= 1'b0;
            ds_pc_reg         <= '0;
            op_reg            <= `OP_NOP;
            op_type_reg       <= `OP_TYPE_NONE;
            rd_reg            <= '0;
            rj_reg            <= '0;
            rk_reg            <= '0;
            imm_unext_reg     <= '0;
            imm_sz_reg        <= `IMM_SZ_NONE;
            shift_imm_reg     <= '0;
            flag_unsigned_reg <= 1'b0;
            ine_reg           <= 1'b0;
        end else begin
            if (flush)
                ds_valid_reg <= 1'b0;
            else if (ds_allowin)
                ds_valid_reg <= fs_to_ds_valid;

            // Fields stay frozen while EX stalls so it sees a stable instruction.
            if (load_fields) begin
                ds_pc_reg         <= fs_pc;
                op_reg            <= op_next;
                op_type_reg       <= op_type_next;
                rd_reg            <= fs_inst[4:0];
                rj_reg            <= fs_inst[9:5];
                rk_reg            <= fs_inst[14:10];
                imm_unext_reg     <= imm_unext_next;
                imm_sz_reg        <= imm_sz_next;
                shift_imm_reg     <= shift_imm_next;
                flag_unsigned_reg <= flag_unsigned_next;
                ine_reg           <= ine_next;
            end
        end
    end

    assign ds_to_es_valid = ds_valid_reg;
    assign ds_pc          = ds_pc_reg;
    assign op             = op_reg;
    assign op_type        = op_type_reg;
    assign rd             = rd_reg;
    assign rj             = rj_reg;
    assign rk             = rk_reg;
    assign imm_unext      = imm_unext_reg;
    assign imm_sz         = imm_sz_reg;
    assign shift_imm      = shift_imm_reg;
    assign flag_unsigned  = flag_unsigned_reg;
    assign ine            = ine_reg;

endmodule

// File: tb/tb_id_decode_reg.sv
// Directed bench for id_decode_reg: hand-decoded LA32R words, stall/flush and reset behaviour.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
`timescale 1ns/1ps

module tb_id_decode_reg;

    localparam logic [7:0] E_NOP  = 8'd0,  E_ADD  = 8'd1,  E_SUB = 8'd2,  E_SRA = 8'd11;
    localparam logic [7:0] E_SLLI = 8'd12, E_ADDI = 8'd17, E_ORI = 8'd19, E_ANDI = 8'd18;
    localparam logic [7:0] E_LL_W = 8'd23, E_SC_W = 8'd24;
    localparam logic [3:0] T_NONE = 4'd0, T_3R = 4'd1, T_2RI12 = 4'd2, T_2RI14 = 4'd3;
    localparam logic [2:0] S_NONE = 3'd0, S_12 = 3'd1, S_14 = 3'd2;

    logic        clk = 1'b0;
    logic        reset, flush, fs_to_ds_valid, es_allowin;
    logic [31:0] fs_inst, fs_pc;
    logic        ds_allowin, ds_to_es_valid, flag_unsigned, ine;
    logic [31:0] ds_pc;
    logic [7:0]  op;
    logic [3:0]  op_type;
    logic [4:0]  rd, rj, rk, shift_imm;
    logic [25:0] imm_unext;
    logic [2:0]  imm_sz;

    int vectors = 0;
    int miscompares = 0;

    id_decode_reg #(.PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc),
        .op(op), .op_type(op_type), .rd(rd), .rj(rj), .rk(rk),
        .imm_unext(imm_unext), .imm_sz(imm_sz), .shift_imm(shift_imm),
        .flag_unsigned(flag_unsigned), .ine(ine)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1'b1;
        fs_inst        = inst;
        fs_pc          = pc;
        tick();
        $display("inst 0x%08h pc 0x%0h -> op %0d type %0d rd %0d rj %0d rk %0d imm 0x%0h sz %0d sh %0d u %0d ine %0d v %0d",
                 inst, pc, op, op_type, rd, rj, rk, imm_unext, imm_sz, shift_imm, flag_unsigned, ine, ds_to_es_valid);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
        fs_inst = 32'h0; fs_pc = 32'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid",   {31'd0, ds_to_es_valid}, 32'd0);
        chk("rst_allowin", {31'd0, ds_allowin},     32'd1);
        chk("rst_op",      {24'd0, op},             {24'd0, E_NOP});

        offer(32'h00100C41, 32'h1000);            // add.w r1,r2,r3
        chk("add_valid", {31'd0, ds_to_es_valid}, 32'd1);
        chk("add_op",    {24'd0, op},        {24'd0, E_ADD});
        chk("add_type",  {28'd0, op_type},   {28'd0, T_3R});
        chk("add_rd",    {27'd0, rd},        32'd1);
        chk("add_rj",    {27'd0, rj},        32'd2);
        chk("add_rk",    {27'd0, rk},        32'd3);
        chk("add_sz",    {29'd0, imm_sz},    {29'd0, S_NONE});
        chk("add_sh",    {27'd0, shift_imm}, 32'd0);
        chk("add_pc",    ds_pc,              32'h1000);

        offer(32'h02BFFCA4, 32'h1004);            // addi.w r4,r5,-1
        chk("addi_op",  {24'd0, op},           {24'd0, E_ADDI});
        chk("addi_imm", {6'd0, imm_unext},     32'h0000FFF);
        chk("addi_sz",  {29'd0, imm_sz},       {29'd0, S_12});
        chk("addi_u",   {31'd0, flag_unsigned}, 32'd0);
        chk("addi_rd",  {27'd0, rd},           32'd4);
        chk("addi_rj",  {27'd0, rj},           32'd5);

        offer(32'h03A00006, 32'h1008);            // ori r6,r0,0x800
        chk("ori_op",   {24'd0, op},           {24'd0, E_ORI});
        chk("ori_type", {28'd0, op_type},      {28'd0, T_2RI12});
        chk("ori_imm",  {6'd0, imm_unext},     32'h0000800);
        chk("ori_u",    {31'd0, flag_unsigned}, 32'd1);

        offer(32'h0340FC41, 32'h100C);            // andi r1,r2,0x03f
        chk("andi_op",  {24'd0, op},           {24'd0, E_ANDI});
        chk("andi_imm", {6'd0, imm_unext},     32'h000003F);
        chk("andi_u",   {31'd0, flag_unsigned}, 32'd1);

        offer(32'h00409421, 32'h1010);            // slli.w r1,r1,5
        chk("slli_op",   {24'd0, op},        {24'd0, E_SLLI});
        chk("slli_type", {28'd0, op_type},   {28'd0, T_3R});
        chk("slli_sh",   {27'd0, shift_imm}, 32'd5);
        chk("slli_sz",   {29'd0, imm_sz},    {29'd0, S_NONE});

        offer(32'h00181CA4, 32'h1014);            // sra.w r4,r5,r7
        chk("sra_op", {24'd0, op},        {24'd0, E_SRA});
        chk("sra_sh", {27'd0, shift_imm}, 32'd0);
        chk("sra_rk", {27'd0, rk},        32'd7);

        offer(32'h20800007, 32'h1018);            // ll.w r7,r0,-8192
        chk("ll_op",   {24'd0, op},       {24'd0, E_LL_W});
        chk("ll_type", {28'd0, op_type},  {28'd0, T_2RI14});
        chk("ll_sz",   {29'd0, imm_sz},   {29'd0, S_14});
        chk("ll_imm",  {6'd0, imm_unext}, 32'h0002000);
        chk("ll_ine",  {31'd0, ine},      32'd0);

        offer(32'h21FFFC62, 32'h101C);            // sc.w r2,r3,imm14=0x3fff
        chk("sc_op",  {24'd0, op},       {24'd0, E_SC_W});
        chk("sc_imm", {6'd0, imm_unext}, 32'h0003FFF);

        offer(32'hFFFFFFFF, 32'h1020);            // unsupported encoding
        chk("ine_flag",  {31'd0, ine},            32'd1);
        chk("ine_op",    {24'd0, op},             {24'd0, E_NOP});
        chk("ine_type",  {28'd0, op_type},        {28'd0, T_NONE});
        chk("ine_imm",   {6'd0, imm_unext},       32'd0);
        chk("ine_valid", {31'd0, ds_to_es_valid}, 32'd1);

        // Stall: EX refuses while a new sub.w r1,r2,r3 is offered.
        es_allowin = 1'b0;
        fs_inst    = 32'h00110C41;
        fs_pc      = 32'h2000;
        #1;
        chk("stall_allowin", {31'd0, ds_allowin}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("stall cycle %0d: op %0d pc 0x%0h allowin %0d", i, op, ds_pc, ds_allowin);
            chk("stall_op",  {24'd0, op},             {24'd0, E_NOP});
            chk("stall_ine", {31'd0, ine},            32'd1);
            chk("stall_pc",  ds_pc,                   32'h1020);
            chk("stall_v",   {31'd0, ds_to_es_valid}, 32'd1);
        end
        es_allowin = 1'b1;
        tick();
        $display("release: op %0d pc 0x%0h", op, ds_pc);
        chk("rel_op",  {24'd0, op},  {24'd0, E_SUB});
        chk("rel_pc",  ds_pc,        32'h2000);
        chk("rel_ine", {31'd0, ine}, 32'd0);

        // Flush beats a simultaneous capture.
        flush   = 1'b1;
        fs_inst = 32'h00100C41;
        fs_pc   = 32'h3000;
        tick();
        $display("flush: valid %0d", ds_to_es_valid);
        chk("flush_valid", {31'd0, ds_to_es_valid}, 32'd0);
        chk("flush_allow", {31'd0, ds_allowin},     32'd1);
        flush = 1'b0;

        // Reset in the middle of a valid stream.
        offer(32'h00100C41, 32'h4000);
        chk("pre_rst_valid", {31'd0, ds_to_es_valid}, 32'd1);
        reset = 1'b1;
        tick();
        $display("mid reset: valid %0d op %0d rd %0d pc 0x%0h", ds_to_es_valid, op, rd, ds_pc);
        reset = 1'b0;
        fs_to_ds_valid = 1'b0;
        chk("mrst_valid", {31'd0, ds_to_es_valid}, 32'd0);
        chk("mrst_allow", {31'd0, ds_allowin},     32'd1);
        chk("mrst_op",    {24'd0, op},             {24'd0, E_NOP});
        chk("mrst_type",  {28'd0, op_type},        {28'd0, T_NONE});
        chk("mrst_rd",    {27'd0, rd},             32'd0);
        chk("mrst_rj",    {27'd0, rj},             32'd0);
        chk("mrst_pc",    ds_pc,                   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
